// File: rtl/rr_pick.sv
// Round-robin picker: rotates the request vector so that 'ptr' is at bit 0,
// priority-encodes the lowest set bit, then rotates the index back.
module rr_pick #(
  parameter  int NR_REQ = 4,
  localparam int ID_LEN = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req,
  input  logic [ID_LEN-1:0] ptr,
  output logic [ID_LEN-1:0] gnt_id,
  output logic              any
);

  logic [NR_REQ-1:0] rot;
  logic [ID_LEN-1:0] off;
  logic              found;

  // Sums stay below 2*NR_REQ, so a single subtract is enough to wrap.
  function automatic int wrapIdx(input int v);
    return (v >= NR_REQ) ? v - NR_REQ : v;
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      rot[i] = req[ID_LEN'(wrapIdx(int'(ptr) + i))];
    end
  end

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = ID_LEN'(i);
      end
    end
  end

  assign gnt_id = ID_LEN'(wrapIdx(int'(ptr) + int'(off)));
  assign any    = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that funnels NR_REQ valid/ready requesters into one
// registered output channel with same-cycle drain and refill.
module rr_mux_arbiter #(
  parameter  int NR_REQ   = 4,
  parameter  int DATA_LEN = 8,
  localparam int ID_LEN   = $clog2(NR_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_REQ-1:0]          req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0] req_data,
  output logic [NR_REQ-1:0]          req_ready,
  output logic                       out_valid,
  output logic [DATA_LEN-1:0]        out_data,
  output logic [ID_LEN-1:0]          out_id,
  input  logic                       out_ready
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic                state_q, state_d;
  logic [ID_LEN-1:0]   ptr_q, ptr_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic [ID_LEN-1:0]   id_q, id_d;
  logic [ID_LEN-1:0]   gnt_id;
  logic                any_req;
  logic                can_accept;
  logic                accept;
  logic [DATA_LEN-1:0] sel_data;

  rr_pick #(.NR_REQ(NR_REQ)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Ready is gated by rst_n so no requester sees a handshake during reset.
  always_comb begin
    can_accept = (state_q == EMPTY) || out_ready;
    accept     = can_accept && any_req;
    req_ready  = '0;
    if (accept && rst_n) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int n = 0; n < NR_REQ; n++) begin
      sel_data = sel_data |
                 (req_data[n*DATA_LEN +: DATA_LEN] & {DATA_LEN{gnt_id == ID_LEN'(n)}});
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    id_d   = id_q;
    if (accept) begin
      data_d = sel_data;
      id_d   = gnt_id;
      ptr_d  = (gnt_id == ID_LEN'(NR_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      id_q   <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: stimulus pushes expected beats into a
// queue and an independent monitor pops one per consumed output beat.
module tb_rr_mux_arbiter;

  localparam int NR_REQ   = 4;
  localparam int DATA_LEN = 8;
  localparam int ID_LEN   = 2;

  typedef struct packed {
    logic [ID_LEN-1:0]   id;
    logic [DATA_LEN-1:0] data;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NR_REQ-1:0]          req_valid;
  logic [NR_REQ*DATA_LEN-1:0] req_data;
  logic [NR_REQ-1:0]          req_ready;
  logic                       out_valid;
  logic [DATA_LEN-1:0]        out_data;
  logic [ID_LEN-1:0]          out_id;
  logic                       out_ready;

  beat_t expQ[$];
  beat_t monExp;
  int    checks   = 0;
  int    failures = 0;

  rr_mux_arbiter #(.NR_REQ(NR_REQ), .DATA_LEN(DATA_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR_REQ-1:0] valid, input logic ready);
    req_valid = valid;
    out_ready = ready;
  endtask

  task automatic setData(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  task automatic pushExp(input logic [ID_LEN-1:0] id, input logic [DATA_LEN-1:0] data);
    beat_t b;
    b.id   = id;
    b.data = data;
    expQ.push_back(b);
  endtask

  // A beat is consumed in any cycle where it is held and out_ready is high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat actual=%0h/%0h expected=none", out_id, out_data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("beat_id", 32'(out_id), 32'(monExp.id));
        checkOutput("beat_data", 32'(out_data), 32'(monExp.data));
      end
    end
  end

  logic [ID_LEN-1:0]   rrIds[5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [DATA_LEN-1:0] rrData[5]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
  logic [NR_REQ-1:0]   rrReady[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int beat;
    int cyc;

    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    setData(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    repeat (2) tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkOutput("rst_out_id", 32'(out_id), 32'h0);

    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_req_ready", 32'(req_ready), 32'(rrReady[k]));
      pushExp(rrIds[k], rrData[k]);
      tick();
      checkOutput("rr_out_valid", 32'(out_valid), 32'h1);
    end

    applyStimulus(4'b0100, 1'b0);
    setData(8'hA0, 8'hA1, 8'h5C, 8'hA3);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("bp_req_ready", 32'(req_ready), 32'h0);
      checkOutput("bp_out_id", 32'(out_id), 32'h0);
      checkOutput("bp_out_data", 32'(out_data), 32'hA0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(req_ready), 32'b0100);
    pushExp(2'd2, 8'h5C);
    tick();
    checkOutput("bp_refill_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_refill_id", 32'(out_id), 32'h2);
    checkOutput("bp_refill_data", 32'(out_data), 32'h5C);

    applyStimulus(4'b1010, 1'b1);
    setData(8'h00, 8'h11, 8'h00, 8'h33);
    #1;
    checkOutput("wrap_first_ready", 32'(req_ready), 32'b1000);
    pushExp(2'd3, 8'h33);
    tick();
    checkOutput("wrap_next_ready", 32'(req_ready), 32'b0010);
    pushExp(2'd1, 8'h11);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("drain_out_valid", 32'(out_valid), 32'h0);
    checkOutput("drain_stale_id", 32'(out_id), 32'h1);
    checkOutput("drain_stale_data", 32'(out_data), 32'h11);

    applyStimulus(4'b1111, 1'b0);
    setData(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    #1;
    checkOutput("pre_reset_ready", 32'(req_ready), 32'b0100);
    tick();
    checkOutput("pre_reset_valid", 32'(out_valid), 32'h1);
    checkOutput("pre_reset_id", 32'(out_id), 32'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_out_data", 32'(out_data), 32'h00);
    checkOutput("async_out_id", 32'(out_id), 32'h0);
    checkOutput("async_req_ready", 32'(req_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", 32'(req_ready), 32'b0001);
    out_ready = 1'b1;
    pushExp(2'd0, 8'hA0);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("post_reset_drain", 32'(out_valid), 32'h0);

    beat = 0;
    cyc  = 0;
    while (beat < 10 && cyc < 60) begin
      applyStimulus(4'b0010, (cyc % 2) == 0);
      setData(8'h00, 8'(8'h10 + beat), 8'h00, 8'h00);
      #1;
      if (req_ready[1]) begin
        pushExp(2'd1, 8'(8'h10 + beat));
        beat++;
      end
      tick();
      cyc++;
    end
    checkOutput("stream_beats_accepted", 32'(beat), 32'd10);

    applyStimulus(4'b0000, 1'b1);
    repeat (3) tick();
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    checkOutput("final_out_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
